// File: rtl/calc_op_issuer_if.sv
// Handshake bundle between the operation requester / control logic side
// (master) and the operation issuer (slave).
interface calc_op_issuer_if #(
  parameter int DEPTH = 4
);

  logic                     op_req;
  logic [1:0]               op_sel;
  logic                     op_chain;
  logic                     op_ack;
  logic                     op_err;
  logic [2:0]               funct;
  logic                     funct_valid;
  logic                     funct_ready;
  logic                     mult_done;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     timeout_err;

  modport master (
    output op_req, op_sel, op_chain, funct_ready, mult_done,
    input  op_ack, op_err, funct, funct_valid, busy, fifo_count, timeout_err
  );

  modport slave (
    input  op_req, op_sel, op_chain, funct_ready, mult_done,
    output op_ack, op_err, funct, funct_valid, busy, fifo_count, timeout_err
  );

endinterface

// File: rtl/calc_op_issuer.sv
// Calculator operation issuer: validates and encodes incoming operation
// requests, buffers them in a small FIFO and hands them one at a time to the
// control logic, waiting for the datapath to finish multiplies (with timeout).
module calc_op_issuer #(
  parameter int DEPTH        = 4,
  parameter int MULT_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_op_issuer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (MULT_TIMEOUT > 2) ? $clog2(MULT_TIMEOUT) : 1;

  localparam logic [2:0] FUNCT_ADD    = 3'b000;
  localparam logic [2:0] FUNCT_SUB    = 3'b001;
  localparam logic [2:0] FUNCT_MULT   = 3'b110;
  localparam logic [2:0] FUNCT_ADD_CH = 3'b100;
  localparam logic [2:0] FUNCT_SUB_CH = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    MWAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            prev_valid_q, prev_valid_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      funct_q, funct_d;
  logic            funct_valid_q, funct_valid_d;
  logic            op_ack_q, op_ack_d;
  logic            op_err_q, op_err_d;
  logic            timeout_err_q, timeout_err_d;

  logic [2:0]      mem_q [DEPTH];

  logic [2:0]      req_funct;
  logic            req_ok;
  logic            full;
  logic            push;
  logic            pop;

  // Decode the incoming request into a funct code and decide accept/reject.
  always_comb begin
    req_funct = FUNCT_ADD;
    req_ok    = 1'b0;
    case (bus.op_sel)
      2'b00: begin
        req_funct = bus.op_chain ? FUNCT_ADD_CH : FUNCT_ADD;
        req_ok    = !bus.op_chain || prev_valid_q;
      end
      2'b01: begin
        req_funct = bus.op_chain ? FUNCT_SUB_CH : FUNCT_SUB;
        req_ok    = !bus.op_chain || prev_valid_q;
      end
      2'b10: begin
        req_funct = FUNCT_MULT;
        req_ok    = !bus.op_chain;
      end
      default: begin
        req_funct = FUNCT_ADD;
        req_ok    = 1'b0;
      end
    endcase
    // Fullness uses the registered count so a same-cycle pop never frees a slot.
    full = (count_q == CW'(DEPTH));
    push = bus.op_req && req_ok && !full;
  end

  // Next-state logic for the issue FSM, the queue pointers and all pulses.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    timer_d       = timer_q;
    funct_d       = funct_q;
    funct_valid_d = funct_valid_q;
    pop           = 1'b0;
    op_ack_d      = push;
    op_err_d      = bus.op_req && !push;
    timeout_err_d = 1'b0;
    prev_valid_d  = prev_valid_q || (push && !bus.op_chain);

    case (state_q)
      IDLE: begin
        funct_valid_d = 1'b0;
        if (count_q != '0) begin
          funct_d       = mem_q[rd_ptr_q];
          funct_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.funct_ready) begin
          pop           = 1'b1;
          funct_valid_d = 1'b0;
          timer_d       = '0;
          state_d       = (funct_q == FUNCT_MULT) ? MWAIT : IDLE;
        end
      end
      MWAIT: begin
        funct_valid_d = 1'b0;
        if (bus.mult_done) begin
          state_d = IDLE;
        end else if (timer_q == TW'(MULT_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        funct_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register all FSM state, queue bookkeeping and outputs; reset discards everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      prev_valid_q  <= 1'b0;
      timer_q       <= '0;
      funct_q       <= 3'b000;
      funct_valid_q <= 1'b0;
      op_ack_q      <= 1'b0;
      op_err_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      prev_valid_q  <= prev_valid_d;
      timer_q       <= timer_d;
      funct_q       <= funct_d;
      funct_valid_q <= funct_valid_d;
      op_ack_q      <= op_ack_d;
      op_err_q      <= op_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Queue storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_funct;
    end
  end

  assign bus.op_ack      = op_ack_q;
  assign bus.op_err      = op_err_q;
  assign bus.funct       = funct_q;
  assign bus.funct_valid = funct_valid_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.fifo_count  = count_q;
  assign bus.busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_calc_op_issuer.sv
// Directed testbench for calc_op_issuer (DEPTH=4, MULT_TIMEOUT=32).
module tb_calc_op_issuer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  calc_op_issuer_if #(.DEPTH(4)) bus ();

  calc_op_issuer #(.DEPTH(4), .MULT_TIMEOUT(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if a task stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] sel, input logic chain);
    bus.op_req   = 1'b1;
    bus.op_sel   = sel;
    bus.op_chain = chain;
  endtask

  task automatic idle_req();
    bus.op_req   = 1'b0;
    bus.op_sel   = 2'b00;
    bus.op_chain = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_req();
    bus.funct_ready = 1'b0;
    bus.mult_done   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) until funct_valid is seen high; does no checking itself.
  task automatic wait_valid(output bit found, output logic [2:0] f);
    found = 1'b0;
    f     = 3'b000;
    for (int i = 0; i < 50; i++) begin
      if (bus.funct_valid === 1'b1) begin
        found = 1'b1;
        f     = bus.funct;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.funct_ready = 1'b1;
    bus.mult_done   = 1'b0;
    drive_req(2'b00, 1'b0);
    tick();
    tick();
    checks++; if (bus.funct_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_funct_valid: got %0b expected 0", bus.funct_valid); end
    checks++; if (bus.funct !== 3'b000) begin errors++; $display("[TB] FAIL rst_funct: got %03b expected 000", bus.funct); end
    checks++; if (bus.op_ack !== 1'b0 || bus.op_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack_err: got %0b%0b expected 00", bus.op_ack, bus.op_err); end
    checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy_to: got %0b%0b expected 00", bus.busy, bus.timeout_err); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", bus.fifo_count); end
    rst_n = 1'b1;
    idle_req();
    tick();
    checks++; if (bus.op_ack !== 1'b0 || bus.op_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ignored: got %0b%0b expected 00", bus.op_ack, bus.op_err); end
    checks++; if (bus.fifo_count !== 3'd0 || bus.funct_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_no_push: got count %0d valid %0b expected 0 0", bus.fifo_count, bus.funct_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.funct_ready = 1'b1;
    drive_req(2'b00, 1'b0);
    tick();
    idle_req();
    checks++; if (bus.op_ack !== 1'b1 || bus.op_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack: got ack %0b err %0b expected 1 0", bus.op_ack, bus.op_err); end
    checks++; if (bus.funct_valid !== 1'b0 || bus.fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL basic_n1: got valid %0b count %0d expected 0 1", bus.funct_valid, bus.fifo_count); end
    tick();
    checks++; if (bus.funct_valid !== 1'b1 || bus.funct !== 3'b000) begin errors++; $display("[TB] FAIL basic_n2: got valid %0b funct %03b expected 1 000", bus.funct_valid, bus.funct); end
    checks++; if (bus.op_ack !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_pulse: got %0b expected 0", bus.op_ack); end
    tick();
    checks++; if (bus.funct_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_done: got valid %0b count %0d busy %0b expected 0 0 0", bus.funct_valid, bus.fifo_count, bus.busy); end
  endtask

  task automatic test_chain();
    bit         found;
    logic [2:0] f;
    do_reset();
    drive_req(2'b01, 1'b1);
    tick();
    idle_req();
    checks++; if (bus.op_err !== 1'b1 || bus.op_ack !== 1'b0) begin errors++; $display("[TB] FAIL chain_noprev: got err %0b ack %0b expected 1 0", bus.op_err, bus.op_ack); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL chain_noprev_count: got %0d expected 0", bus.fifo_count); end
    drive_req(2'b00, 1'b0);
    tick();
    drive_req(2'b01, 1'b1);
    tick();
    idle_req();
    checks++; if (bus.op_ack !== 1'b1 || bus.fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL chain_push: got ack %0b count %0d expected 1 2", bus.op_ack, bus.fifo_count); end
    checks++; if (bus.funct_valid !== 1'b1 || bus.funct !== 3'b000) begin errors++; $display("[TB] FAIL chain_first: got valid %0b funct %03b expected 1 000", bus.funct_valid, bus.funct); end
    bus.funct_ready = 1'b1;
    tick();
    wait_valid(found, f);
    checks++; if (!found || f !== 3'b101) begin errors++; $display("[TB] FAIL chain_second: got found %0b funct %03b expected 1 101", found, f); end
    tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.funct_valid !== 1'b0) begin errors++; $display("[TB] FAIL chain_drain: got count %0d valid %0b expected 0 0", bus.fifo_count, bus.funct_valid); end
  endtask

  task automatic test_reject();
    do_reset();
    drive_req(2'b00, 1'b0);
    tick();
    drive_req(2'b10, 1'b1);
    tick();
    checks++; if (bus.op_err !== 1'b1 || bus.op_ack !== 1'b0) begin errors++; $display("[TB] FAIL reject_mult_chain: got err %0b ack %0b expected 1 0", bus.op_err, bus.op_ack); end
    drive_req(2'b11, 1'b0);
    tick();
    idle_req();
    checks++; if (bus.op_err !== 1'b1 || bus.op_ack !== 1'b0) begin errors++; $display("[TB] FAIL reject_reserved: got err %0b ack %0b expected 1 0", bus.op_err, bus.op_ack); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL reject_count: got %0d expected 1", bus.fifo_count); end
    tick();
    checks++; if (bus.op_err !== 1'b0) begin errors++; $display("[TB] FAIL reject_pulse: got %0b expected 0", bus.op_err); end
  endtask

  task automatic test_full();
    logic [1:0] sel_tab [5]   = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    logic       chain_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_tab [3]   = '{3'b101, 3'b100, 3'b001};
    bit         found;
    logic [2:0] f;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_req(sel_tab[i], chain_tab[i]);
      tick();
      checks++;
      if (bus.op_ack !== (i < 4) || bus.op_err !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL full_req%0d: got ack %0b err %0b expected %0b %0b", i, bus.op_ack, bus.op_err, (i < 4), (i == 4));
      end
    end
    idle_req();
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", bus.fifo_count); end
    checks++; if (bus.funct_valid !== 1'b1 || bus.funct !== 3'b000) begin errors++; $display("[TB] FAIL full_head: got valid %0b funct %03b expected 1 000", bus.funct_valid, bus.funct); end
    bus.funct_ready = 1'b1;
    drive_req(2'b00, 1'b0);
    tick();
    idle_req();
    checks++; if (bus.op_err !== 1'b1 || bus.op_ack !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_same_cycle: got err %0b ack %0b expected 1 0", bus.op_err, bus.op_ack); end
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_count: got %0d expected 3", bus.fifo_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      wait_valid(found, f);
      checks++;
      if (!found || f !== exp_tab[i]) begin
        errors++;
        $display("[TB] FAIL full_order%0d: got found %0b funct %03b expected 1 %03b", i, found, f, exp_tab[i]);
      end
    end
    tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL full_drained: got count %0d busy %0b expected 0 0", bus.fifo_count, bus.busy); end
  endtask

  task automatic test_back_to_back();
    bit         found;
    logic [2:0] f;
    do_reset();
    drive_req(2'b00, 1'b0);
    tick();
    drive_req(2'b01, 1'b0);
    tick();
    bus.funct_ready = 1'b1;
    drive_req(2'b00, 1'b1);
    tick();
    idle_req();
    checks++; if (bus.op_ack !== 1'b1 || bus.fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL b2b_push_pop: got ack %0b count %0d expected 1 2", bus.op_ack, bus.fifo_count); end
    wait_valid(found, f);
    checks++; if (!found || f !== 3'b001) begin errors++; $display("[TB] FAIL b2b_first: got found %0b funct %03b expected 1 001", found, f); end
    tick();
    wait_valid(found, f);
    checks++; if (!found || f !== 3'b100) begin errors++; $display("[TB] FAIL b2b_second: got found %0b funct %03b expected 1 100", found, f); end
    tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got count %0d busy %0b expected 0 0", bus.fifo_count, bus.busy); end
  endtask

  task automatic test_mult();
    bit         found;
    logic [2:0] f;
    int         early;
    do_reset();
    bus.funct_ready = 1'b1;
    drive_req(2'b10, 1'b0);
    tick();
    drive_req(2'b00, 1'b0);
    tick();
    idle_req();
    wait_valid(found, f);
    checks++; if (!found || f !== 3'b110) begin errors++; $display("[TB] FAIL mult_issue: got found %0b funct %03b expected 1 110", found, f); end
    tick();
    early = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.funct_valid !== 1'b0 || bus.busy !== 1'b1) early++;
      tick();
    end
    checks++; if (early != 0) begin errors++; $display("[TB] FAIL mult_wait_hold: got %0d bad cycles expected 0", early); end
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0 || bus.funct_valid !== 1'b0) begin errors++; $display("[TB] FAIL mult_done: got to %0b valid %0b expected 0 0", bus.timeout_err, bus.funct_valid); end
    wait_valid(found, f);
    checks++; if (!found || f !== 3'b000) begin errors++; $display("[TB] FAIL mult_next: got found %0b funct %03b expected 1 000", found, f); end
    tick();
  endtask

  task automatic test_timeout();
    bit         found;
    logic [2:0] f;
    int         seen;
    do_reset();
    bus.funct_ready = 1'b1;
    drive_req(2'b10, 1'b0);
    tick();
    idle_req();
    wait_valid(found, f);
    tick();
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.timeout_err === 1'b1) begin
        seen = k;
        break;
      end
    end
    checks++; if (seen != 32) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 32", seen); end
    tick();
    checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse: got to %0b busy %0b expected 0 0", bus.timeout_err, bus.busy); end
    drive_req(2'b10, 1'b0);
    tick();
    idle_req();
    wait_valid(found, f);
    tick();
    for (int k = 1; k <= 31; k++) tick();
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_vs_done: got to %0b busy %0b expected 0 0", bus.timeout_err, bus.busy); end
  endtask

  task automatic test_mid_reset();
    int issued;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_req(2'b00, 1'b0);
      tick();
    end
    idle_req();
    checks++; if (bus.funct_valid !== 1'b1 || bus.fifo_count !== 3'd3) begin errors++; $display("[TB] FAIL midrst_pre: got valid %0b count %0d expected 1 3", bus.funct_valid, bus.fifo_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.funct_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_post: got valid %0b count %0d busy %0b expected 0 0 0", bus.funct_valid, bus.fifo_count, bus.busy); end
    bus.funct_ready = 1'b1;
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.funct_valid === 1'b1) issued++;
    end
    checks++; if (issued != 0) begin errors++; $display("[TB] FAIL midrst_no_issue: got %0d issues expected 0", issued); end
    drive_req(2'b01, 1'b1);
    tick();
    idle_req();
    checks++; if (bus.op_err !== 1'b1) begin errors++; $display("[TB] FAIL midrst_prev_cleared: got err %0b expected 1", bus.op_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_req();
    bus.funct_ready = 1'b0;
    bus.mult_done   = 1'b0;
    test_reset();
    test_basic();
    test_chain();
    test_reject();
    test_full();
    test_back_to_back();
    test_mult();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
